// File: rtl/mem_arbiter.sv
// Multi-channel memory arbiter: grants one word-wide requester at a time and
// serialises its transfer into RAM_DW-bit beats on a single shared RAM port.
module mem_arbiter #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned RAM_DW   = 8,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned RR_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        we_i,
  input  logic [NUM_CH*AW-1:0]     addr_i,
  input  logic [NUM_CH*DW-1:0]     wdata_i,
  input  logic [NUM_CH*(DW/8)-1:0] sel_i,
  output logic [DW-1:0]            rdata_o,
  output logic [NUM_CH-1:0]        done_o,
  output logic [NUM_CH-1:0]        busy_o,
  output logic [NUM_CH-1:0]        grant_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [RAM_DW-1:0]        mem_dout_o,
  output logic                     mem_wr_o,
  input  logic [RAM_DW-1:0]        mem_din_i
);

  localparam int unsigned BEATS = DW / RAM_DW;
  localparam int unsigned BPB   = RAM_DW / 8;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned CW    = $clog2(BEATS + READ_LAT + 2);
  localparam int unsigned PW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PL    = (READ_LAT > 0) ? READ_LAT : 1;
  localparam int unsigned WL    = (READ_LAT > 0) ? READ_LAT - 1 : 0;

  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic [CW-1:0]       beat_q, beat_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NUM_CH-1:0]   holdoff_q, holdoff_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [DW-1:0]       rbuf_q, rbuf_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [RAM_DW-1:0]   mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic [PL-1:0]       pv_q, pv_d;
  logic [CW-1:0]       pidx_q [PL];
  logic [CW-1:0]       pidx_d [PL];

  logic [NUM_CH-1:0]   elig;
  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [NUM_CH-1:0]   win_oh;
  logic                g_we;
  logic [AW-1:0]       g_addr;
  logic [DW-1:0]       g_wdata;
  logic [SW-1:0]       g_sel;
  logic                cap_v;
  logic [CW-1:0]       cap_idx;

  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign grant_o    = grant_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_dout_o = mem_dout_q;
  assign mem_wr_o   = mem_wr_q;
  assign busy_o     = req_i & ~done_q;

  // Winner selection; the channel served last is masked for one IDLE cycle
  always_comb begin
    elig      = req_i & ~holdoff_q;
    win_found = 1'b0;
    win_idx   = '0;
    g_we      = 1'b0;
    g_addr    = '0;
    g_wdata   = '0;
    g_sel     = '0;
    for (int unsigned s = 0; s < NUM_CH; s++) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (!win_found && elig[i]) begin
          if (RR_MODE == 0) begin
            if (s == 0) begin
              win_found = 1'b1;
              win_idx   = PW'(i);
            end
          end else if (((32'(ptr_q) + 32'd1 + s) % NUM_CH) == i) begin
            win_found = 1'b1;
            win_idx   = PW'(i);
          end
        end
      end
    end
    win_oh = win_found ? (NUM_CH'(1) << win_idx) : '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (win_idx == PW'(i)) begin
        g_we    = we_i[i];
        g_addr  = addr_i[i*AW +: AW];
        g_wdata = wdata_i[i*DW +: DW];
        g_sel   = sel_i[i*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (win_found) state_d = XFER;
      XFER: if (beat_q == CW'(BEATS - 1)) state_d = (we_q || READ_LAT == 0) ? DONE : WAIT;
      WAIT: if (beat_q == CW'(WL)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so beat k appears in XFER cycle k
  always_comb begin
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    beat_d     = '0;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    mem_addr_d = mem_addr_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          we_d    = g_we;
          addr_d  = g_addr;
          wdata_d = g_wdata;
          sel_d   = g_sel;
          grant_d = win_oh;
          owner_d = win_idx;
        end
      end
      XFER: beat_d = (beat_q == CW'(BEATS - 1)) ? '0 : beat_q + CW'(1);
      WAIT: beat_d = beat_q + CW'(1);
      DONE: begin
        grant_d = '0;
        ptr_d   = owner_q;
      end
      default: ;
    endcase
    holdoff_d = (state_q == DONE) ? grant_q : '0;
    done_d    = (state_d == DONE) ? grant_q : '0;
    if (state_d == XFER) begin
      mem_addr_d = addr_d + AW'(beat_d) * AW'(BPB);
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (beat_d == CW'(k)) begin
          mem_dout_d = wdata_d[k*RAM_DW +: RAM_DW];
          mem_wr_d   = we_d & (|sel_d[k*BPB +: BPB]);
        end
      end
    end

    // Read-beat tracking: each issued beat index is delayed READ_LAT cycles to its capture
    pv_d[0]   = (state_q == XFER) && !we_q;
    pidx_d[0] = beat_q;
    for (int unsigned j = 1; j < PL; j++) begin
      pv_d[j]   = pv_q[j-1];
      pidx_d[j] = pidx_q[j-1];
    end
    cap_v   = (READ_LAT == 0) ? pv_d[0] : pv_q[PL-1];
    cap_idx = (READ_LAT == 0) ? beat_q  : pidx_q[PL-1];
    rbuf_d  = rbuf_q;
    if (cap_v) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (cap_idx == CW'(k)) rbuf_d[k*RAM_DW +: RAM_DW] = mem_din_i;
      end
    end
    rdata_d = (state_d == DONE && !we_q) ? rbuf_d : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      beat_q     <= '0;
      owner_q    <= '0;
      ptr_q      <= PW'(NUM_CH - 1);
      holdoff_q  <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      rbuf_q     <= '0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      pv_q       <= '0;
      for (int unsigned j = 0; j < PL; j++) pidx_q[j] <= '0;
    end else begin
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      beat_q     <= beat_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      holdoff_q  <= holdoff_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      rbuf_q     <= rbuf_d;
      mem_addr_q <= mem_addr_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      pv_q       <= pv_d;
      for (int unsigned j = 0; j < PL; j++) pidx_q[j] <= pidx_d[j];
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: default instance (fixed priority, 8-bit RAM,
// READ_LAT=1) and a 64/16-bit round-robin instance with READ_LAT=0.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  logic [1:0]  req1, we1, done1, busy1, grant1;
  logic [63:0] addr1, wdata1;
  logic [7:0]  sel1, mdout1, mdin1;
  logic [31:0] rdata1, maddr1;
  logic        mwr1;

  logic [1:0]   req2, we2, done2, busy2, grant2;
  logic [63:0]  addr2;
  logic [127:0] wdata2;
  logic [15:0]  sel2, mdout2, mdin2;
  logic [63:0]  rdata2;
  logic [31:0]  maddr2;
  logic         mwr2;

  int errors;
  int checks;

  logic [7:0] mem1 [0:65535];
  bit         wr1  [0:65535];
  logic [7:0] mem2 [0:255];

  mem_arbiter dut1 (
    .clk(clk), .rst(rst), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .sel_i(sel1), .rdata_o(rdata1), .done_o(done1),
    .busy_o(busy1), .grant_o(grant1), .mem_addr_o(maddr1),
    .mem_dout_o(mdout1), .mem_wr_o(mwr1), .mem_din_i(mdin1)
  );

  mem_arbiter #(.NUM_CH(2), .AW(32), .DW(64), .RAM_DW(16), .READ_LAT(0), .RR_MODE(1)) dut2 (
    .clk(clk), .rst(rst), .req_i(req2), .we_i(we2), .addr_i(addr2),
    .wdata_i(wdata2), .sel_i(sel2), .rdata_o(rdata2), .done_o(done2),
    .busy_o(busy2), .grant_o(grant2), .mem_addr_o(maddr2),
    .mem_dout_o(mdout2), .mem_wr_o(mwr2), .mem_din_i(mdin2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM with one cycle read latency
  always @(posedge clk) begin
    if (mwr1) begin
      mem1[maddr1[15:0]] <= mdout1;
      wr1[maddr1[15:0]]  <= 1'b1;
    end
    mdin1 <= mem1[maddr1[15:0]];
  end

  // 16-bit RAM with combinational read
  always @(posedge clk) begin
    if (mwr2) begin
      mem2[maddr2[7:0]]         <= mdout2[7:0];
      mem2[maddr2[7:0] + 8'd1]  <= mdout2[15:8];
    end
  end
  assign mdin2 = {mem2[maddr2[7:0] + 8'd1], mem2[maddr2[7:0]]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One dut1 transaction driven in an IDLE cycle (cycle 0), checked cycle by cycle
  task automatic txn1(input int ch, input bit w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input int lat, output logic [31:0] rd);
    logic [1:0] oh;
    oh = 2'b01 << ch;
    req1[ch] = 1'b1;
    we1[ch]  = w;
    addr1[ch*32 +: 32]  = a;
    wdata1[ch*32 +: 32] = wd;
    sel1[ch*4 +: 4]     = s;
    for (int c = 1; c < lat; c++) begin
      @(negedge clk);
      chk("grant", grant1, oh);
      chk("done_early", done1, 2'b00);
      if (c <= 4) begin
        chk("beat_addr", maddr1, a + 32'(c - 1));
        chk("beat_wr", mwr1, w & s[c-1]);
        if (w) chk("beat_data", mdout1, wd[8*(c-1) +: 8]);
      end else begin
        chk("wait_wr", mwr1, 1'b0);
        chk("addr_hold", maddr1, a + 32'd3);
      end
    end
    @(negedge clk);
    chk("done", done1, oh);
    chk("busy_release", busy1[ch], 1'b0);
    chk("done_wr", mwr1, 1'b0);
    rd = rdata1;
    req1[ch] = 1'b0;
    @(negedge clk);
    chk("grant_clear", grant1, 2'b00);
    chk("done_pulse", done1, 2'b00);
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [31:0] exp_a [4];
  logic [15:0] exp_d [4];

  initial begin
    errors = 0;
    checks = 0;
    req1 = '0; we1 = '0; addr1 = '0; wdata1 = '0; sel1 = '0;
    req2 = '0; we2 = '0; addr2 = '0; wdata2 = '0; sel2 = '0;
    exp_a = '{32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0002};
    exp_d = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    rst = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_grant", grant1, 2'b00);
    chk("rst_done", done1, 2'b00);
    chk("rst_wr", mwr1, 1'b0);
    chk("rst_addr", maddr1, 32'h0);
    chk("rst_dout", mdout1, 8'h0);
    chk("rst_rdata", rdata1, 32'h0);
    chk("rst_busy", busy1, 2'b00);
    chk("rst_grant2", grant2, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // ch1 full write
    txn1(1, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'b1111, 5, rd);
    chk("ram_1000", mem1[16'h1000], 8'hEF);
    chk("ram_1001", mem1[16'h1001], 8'hBE);
    chk("ram_1002", mem1[16'h1002], 8'hAD);
    chk("ram_1003", mem1[16'h1003], 8'hDE);
    chk("rdata_after_wr", rdata1, 32'h0);

    // ch0 write then read back
    txn1(0, 1'b1, 32'h20, 32'h4433_2211, 4'b1111, 5, rd);
    txn1(0, 1'b0, 32'h20, 32'h0, 4'b0000, 6, rd);
    chk("read_word", rd, 32'h4433_2211);
    chk("rdata_hold", rdata1, 32'h4433_2211);

    // partial-lane write
    txn1(1, 1'b1, 32'h40, 32'hA1B2_C3D4, 4'b0101, 5, rd);
    chk("sel_ram_40", mem1[16'h0040], 8'hD4);
    chk("sel_ram_42", mem1[16'h0042], 8'hB2);
    chk("sel_skip_41", wr1[16'h0041], 1'b0);
    chk("sel_skip_43", wr1[16'h0043], 1'b0);
    chk("rdata_wr_keep", rdata1, 32'h4433_2211);

    // reset in the middle of a ch0 write, before beat 2
    req1 = 2'b01; we1 = 2'b01;
    addr1[31:0] = 32'h100; wdata1[31:0] = 32'h1234_5678; sel1[3:0] = 4'hF;
    @(negedge clk);
    chk("mr_beat0", maddr1, 32'h100);
    @(negedge clk);
    chk("mr_beat1_wr", mwr1, 1'b1);
    chk("mr_beat1", maddr1, 32'h101);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_wr", mwr1, 1'b0);
    chk("mr_grant", grant1, 2'b00);
    chk("mr_done", done1, 2'b00);
    rst = 1'b0;
    req1 = 2'b00;
    @(negedge clk);
    chk("mr_no_done", done1, 2'b00);
    chk("mr_ram_100", mem1[16'h0100], 8'h78);
    chk("mr_ram_101", mem1[16'h0101], 8'h56);
    chk("mr_skip_102", wr1[16'h0102], 1'b0);
    chk("mr_skip_103", wr1[16'h0103], 1'b0);
    chk("mr_rdata", rdata1, 32'h0);
    @(negedge clk);

    // both channels held, fixed priority: ch1 only gets in during ch0's hold-off
    req1 = 2'b11; we1 = 2'b11;
    addr1 = {32'h300, 32'h200}; wdata1 = {32'h5555_6666, 32'h7777_8888}; sel1 = 8'hFF;
    @(negedge clk);
    chk("fp_grant0", grant1, 2'b01);
    chk("fp_busy", busy1, 2'b11);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("fp_done0", done1, 2'b01);
    chk("fp_busy_d", busy1, 2'b10);
    @(negedge clk);
    chk("fp_holdoff", grant1, 2'b00);
    @(negedge clk);
    chk("fp_grant1", grant1, 2'b10);
    chk("fp_addr1", maddr1, 32'h300);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("fp_done1", done1, 2'b10);
    req1 = 2'b00;
    repeat (2) @(negedge clk);

    // fixed priority after ch0 was served: ch0 still wins once hold-off lapses
    txn1(0, 1'b1, 32'h60, 32'h0102_0304, 4'b1111, 5, rd);
    req1 = 2'b11; we1 = 2'b11;
    @(negedge clk);
    chk("fp_prio", grant1, 2'b01);
    repeat (4) @(negedge clk);
    chk("fp_prio_done", done1, 2'b01);
    req1 = 2'b00;
    repeat (2) @(negedge clk);

    // dut2: 64-bit write across the address wrap
    req2 = 2'b01; we2 = 2'b01;
    addr2[31:0] = 32'hFFFF_FFFC; wdata2[63:0] = 64'h0123_4567_89AB_CDEF; sel2[7:0] = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("w2_addr", maddr2, exp_a[c]);
      chk("w2_data", mdout2, exp_d[c]);
      chk("w2_wr", mwr2, 1'b1);
      chk("w2_grant", grant2, 2'b01);
    end
    @(negedge clk);
    chk("w2_done", done2, 2'b01);
    req2 = 2'b00;
    repeat (2) @(negedge clk);

    // dut2: read back, READ_LAT=0 so done at cycle 5
    req2 = 2'b01; we2 = 2'b00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("r2_addr", maddr2, exp_a[c]);
      chk("r2_wr", mwr2, 1'b0);
      chk("r2_done_early", done2, 2'b00);
    end
    @(negedge clk);
    chk("r2_done", done2, 2'b01);
    chk("r2_busy", busy2, 2'b00);
    chk("r2_rdata", rdata2, 64'h0123_4567_89AB_CDEF);
    req2 = 2'b00;
    repeat (2) @(negedge clk);

    // dut2 round-robin: ch0 served last, so ch1 wins, then ch0
    req2 = 2'b11; we2 = 2'b11;
    addr2 = {32'h40, 32'h80}; wdata2 = '0; sel2 = 16'hFFFF;
    @(negedge clk);
    chk("rr_grant1", grant2, 2'b10);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("rr_done1", done2, 2'b10);
    @(negedge clk);
    chk("rr_idle", grant2, 2'b00);
    @(negedge clk);
    chk("rr_grant0", grant2, 2'b01);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("rr_done0", done2, 2'b01);
    req2 = 2'b00;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised multi-channel memory arbiter and width adapter for the core's next generation.
- Replaces the separate instruction-ROM and data-RAM ports with one narrow shared RAM port.
- Serves NUM_CH word-wide requesters (default: ch0 = instruction fetch, ch1 = cache/MEM). Each transfer is serialised into RAM_DW-bit beats.
- Per-channel busy lines feed the pipeline ctrl stall logic.

Parameters:
- NUM_CH, 2, number of requester channels (1..8).
- AW, 32, address width (byte address).
- DW, 32, requester word width; multiple of RAM_DW.
- RAM_DW, 8, RAM data width; multiple of 8.
- READ_LAT, 1, RAM read latency in cycles (0..3).
- RR_MODE, 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_i  in  NUM_CH  per-channel request; hold until done_o
- we_i  in  NUM_CH  1 = write, 0 = read
- addr_i  in  NUM_CH*AW  per-channel byte address, channel i in slice i
- wdata_i  in  NUM_CH*DW  per-channel write data
- sel_i  in  NUM_CH*(DW/8)  per-channel byte-lane enables
- rdata_o  out  DW  read word of the last completed read
- done_o  out  NUM_CH  one-cycle completion pulse
- busy_o  out  NUM_CH  stall request to ctrl
- grant_o  out  NUM_CH  one-hot current owner; 0 when idle
- mem_addr_o  out  AW  RAM address
- mem_dout_o  out  RAM_DW  RAM write data
- mem_wr_o  out  1  RAM write strobe
- mem_din_i  in  RAM_DW  RAM read data

Behaviour:
- Constants: BEATS = DW/RAM_DW; BPB (bytes per beat) = RAM_DW/8.
- FSM states: IDLE, XFER, WAIT, DONE.
- Reset values: state IDLE; done_o, grant_o, rdata_o, mem_addr_o, mem_dout_o, mem_wr_o all 0; beat counter 0; round-robin pointer = NUM_CH-1, so ch0 is checked first.
- IDLE:
  - If any eligible req_i is set, pick a winner by policy.
  - On that clock edge, latch the winner's we, addr, wdata and sel, set grant_o, and go to XFER.
  - Inputs are not re-sampled after the grant.
- XFER: runs exactly BEATS cycles; beat k (k = 0..BEATS-1) is driven in XFER cycle k.
  - mem_addr_o = addr + k*BPB, modulo 2^AW.
  - Beat order is lane 0 (LSB) first.
  - Write: mem_dout_o = wdata lane k. mem_wr_o = 1 only if any sel bit covering beat k is set, else 0. The cycle is consumed either way, so latency is fixed.
  - Read: mem_wr_o = 0. The data for beat k is captured from mem_din_i READ_LAT cycles after the beat is issued; READ_LAT = 0 captures in the same cycle.
- Next state after the last beat:
  - Write: DONE.
  - Read with READ_LAT > 0: WAIT for READ_LAT cycles, then DONE.
  - Read with READ_LAT = 0: DONE.
- Outside XFER, mem_wr_o = 0 and mem_addr_o/mem_dout_o hold their last values.
- DONE (one cycle):
  - done_o[owner] = 1.
  - On reads, rdata_o is valid in this cycle and holds until the next read completes; writes leave rdata_o unchanged.
  - Then go to IDLE, clear grant_o, and advance the round-robin pointer to the owner.
- Latency, with the request sampled in IDLE at cycle 0: write done_o at cycle BEATS+1; read done_o at cycle BEATS+READ_LAT+1. Default values: write 5, read 6.
- busy_o[i] = req_i[i] & ~done_o[i] (combinational).
  - ctrl releases the stall in the done cycle.
  - The requester drops or changes req_i from the next cycle on.
- Hold-off: in the first IDLE cycle after DONE, the channel just served is ineligible. This blocks a stale re-grant; other channels may win that cycle.
- Round-robin: search starts at pointer+1 and wraps.
- Reads ignore sel_i and always return the full word.
- A write with all sel bits 0 completes with normal latency and no mem_wr_o pulse.
- Simultaneous requests: exactly one grant; the others stay busy and wait.
- Reset mid-transfer: returns to IDLE at once, no done_o pulse. Bytes already written remain in RAM; the partially read word is discarded.

Test Plan:
- Reset mid-XFER of a ch0 write at beat 2 → next cycle mem_wr_o=0, grant_o=0, done_o=0; bytes at 0x100..0x101 written, 0x102..0x103 untouched.
- Ch1 write, addr=0x1000, wdata=0xDEADBEEF, sel=4'b1111, READ_LAT=1 → mem_wr_o high cycles 1-4 with addr 0x1000..0x1003 and data EF,BE,AD,DE; done_o[1] at cycle 5.
- Ch0 read, addr=0x20, RAM bytes 11,22,33,44 → rdata_o=0x44332211 with done_o[0] at cycle 6; repeat with READ_LAT=0 → done at cycle 5.
- Ch1 write with sel=4'b0101 → mem_wr_o pulses only on beats 0 and 2; done still at cycle 5.
- Both channels held continuously, RR_MODE=0 → ch0 served repeatedly; ch1 wins only in hold-off cycles. With RR_MODE=1 → grants alternate 0,1,0,1.
- DW=64, RAM_DW=16, addr=0xFFFFFFFC, AW=32 → 4 beats, addresses FFFFFFFC, FFFFFFFE, 00000000, 00000002 (wrap); read done at cycle 4+READ_LAT+1.
